// File: rtl/digpot_pkg.sv
// Shared constants for the digital-pot sequencer.
// FSM encodings, register offsets and register bit positions.
package digpot_pkg;
  localparam logic [2:0] ST_HOME   = 3'd0;
  localparam logic [2:0] ST_IDLE   = 3'd1;
  localparam logic [2:0] ST_SETUP  = 3'd2;
  localparam logic [2:0] ST_INC_LO = 3'd3;
  localparam logic [2:0] ST_INC_HI = 3'd4;
  localparam logic [2:0] ST_TAIL   = 3'd5;
  localparam logic [2:0] ST_STORE  = 3'd6;

  localparam logic [1:0] REG_TARGET = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;

  localparam int TGT_STORE = 8;
  localparam int ST_BUSY   = 8;
  localparam int ST_HOMED  = 9;
  localparam int ST_ERR    = 10;
  localparam int CTRL_HOME = 0;
  localparam int CTRL_CLR  = 2;
endpackage

// File: rtl/digpot_wb_if.sv
// Wishbone slave bundle for the digital-pot sequencer.
// Signal names follow the bus-side port names of the block.
interface digpot_wb_if;
  logic        wb_stb_i;
  logic        wb_cyc_i;
  logic        wb_we_i;
  logic [31:0] wb_adr_i;
  logic [3:0]  wb_sel_i;
  logic [31:0] wb_dat_i;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o;

  modport master (
    output wb_stb_i, wb_cyc_i, wb_we_i,
    output wb_adr_i, wb_sel_i, wb_dat_i,
    input  wb_dat_o, wb_ack_o
  );

  modport slave (
    input  wb_stb_i, wb_cyc_i, wb_we_i,
    input  wb_adr_i, wb_sel_i, wb_dat_i,
    output wb_dat_o, wb_ack_o
  );
endinterface

// File: rtl/digpot_timer.sv
// Loadable down-counter shared by all timed FSM states.
// A state lasting N cycles loads N-1; expire is high in its last cycle.
module digpot_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [W-1:0] load_val,
  output logic         expire
);
  logic [W-1:0] cnt;
  logic         run;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
      run <= 1'b0;
    end else if (start) begin
      cnt <= load_val;
      run <= 1'b1;
    end else if (run) begin
      if (cnt == '0) run <= 1'b0;
      else           cnt <= cnt - 1'b1;
    end
  end

  assign expire = run && (cnt == '0);
endmodule

// File: rtl/digpot_seq.sv
// Wishbone sequencer for an X9C-style up/down digital potentiometer.
// Converts absolute tap writes into timed INC pulse trains.
module digpot_seq
  import digpot_pkg::*;
#(
  parameter int NSTEPS    = 100,
  parameter int POS_W     = 7,
  parameter int HALF_CYC  = 50,
  parameter int SETUP_CYC = 5,
  parameter int STORE_CYC = 1000
) (
  input  logic       clk,
  input  logic       reset,
  digpot_wb_if.slave wb,
  output logic       INC_o,
  output logic       UDn_o,
  output logic       CSn_o,
  output logic       busy_o,
  output logic       done_o
);
  localparam int MAX_HS = (HALF_CYC > SETUP_CYC) ? HALF_CYC : SETUP_CYC;
  localparam int MAXC   = (MAX_HS > STORE_CYC) ? MAX_HS : STORE_CYC;
  localparam int TW     = $clog2(MAXC);

  localparam logic [TW-1:0]    L_SETUP = TW'(SETUP_CYC - 1);
  localparam logic [TW-1:0]    L_HALF  = TW'(HALF_CYC - 1);
  localparam logic [TW-1:0]    L_STORE = TW'(STORE_CYC - 1);
  localparam logic [POS_W-1:0] TOP     = POS_W'(NSTEPS - 1);
  localparam logic [POS_W:0]   NST     = (POS_W+1)'(NSTEPS);

  logic [2:0]       state;
  logic [POS_W-1:0] pos, tgt_q, wtgt;
  logic [POS_W:0]   steps;
  logic st_q, pend_v, err, homed, homing;
  logic mv_store, dir, tail_ph;
  logic acc, wr_any, home_req, go, wclamp;
  logic [1:0]  ra;
  logic [31:0] rdata;
  logic tm_start, tm_exp;
  logic [TW-1:0] tm_val;
  logic unused_ok;

  function automatic logic [POS_W-1:0] step_pos(
    input logic [POS_W-1:0] p,
    input logic             up
  );
    if (up) return (p == TOP) ? p : p + 1'b1;
    return (p == '0) ? p : p - 1'b1;
  endfunction

  assign acc      = wb.wb_stb_i & wb.wb_cyc_i & ~wb.wb_ack_o;
  assign wr_any   = acc & wb.wb_we_i;
  assign ra       = wb.wb_adr_i[3:2];
  assign wclamp   = {1'b0, wb.wb_dat_i[POS_W-1:0]} >= NST;
  assign wtgt     = wclamp ? TOP : wb.wb_dat_i[POS_W-1:0];
  assign home_req = wr_any && (ra == REG_CTRL)
                    && wb.wb_dat_i[CTRL_HOME];
  assign go       = pend_v && ((tgt_q != pos) || st_q);
  assign busy_o   = (state != ST_IDLE);

  assign unused_ok = ^{wb.wb_sel_i, wb.wb_adr_i[31:4],
                       wb.wb_adr_i[1:0], wb.wb_dat_i};

  always_comb begin
    rdata = '0;
    unique case (ra)
      REG_TARGET: begin
        rdata[POS_W-1:0] = tgt_q;
        rdata[TGT_STORE] = st_q;
      end
      REG_STATUS: begin
        rdata[POS_W-1:0] = pos;
        rdata[ST_BUSY]   = busy_o;
        rdata[ST_HOMED]  = homed;
        rdata[ST_ERR]    = err;
      end
      default: rdata = '0;
    endcase
  end

  always_comb begin
    tm_start = 1'b0;
    tm_val   = L_SETUP;
    unique case (state)
      ST_HOME:  tm_start = 1'b1;
      ST_IDLE:  tm_start = !home_req && go;
      ST_SETUP, ST_INC_HI: if (tm_exp) begin
        tm_start = 1'b1;
        tm_val   = (steps != '0) ? L_HALF : L_SETUP;
      end
      ST_INC_LO: if (tm_exp) begin
        tm_start = 1'b1;
        tm_val   = L_HALF;
      end
      ST_TAIL: if (tm_exp && !tail_ph && mv_store) begin
        tm_start = 1'b1;
        tm_val   = L_STORE;
      end
      default: tm_start = 1'b0;
    endcase
  end

  digpot_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .start    (tm_start),
    .load_val (tm_val),
    .expire   (tm_exp)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_HOME;
      pos      <= '0;
      tgt_q    <= '0;
      steps    <= '0;
      st_q     <= 1'b0;
      pend_v   <= 1'b0;
      err      <= 1'b0;
      homed    <= 1'b0;
      homing   <= 1'b0;
      mv_store <= 1'b0;
      dir      <= 1'b0;
      tail_ph  <= 1'b0;
      INC_o    <= 1'b1;
      UDn_o    <= 1'b0;
      CSn_o    <= 1'b1;
      done_o   <= 1'b0;
      wb.wb_ack_o <= 1'b0;
      wb.wb_dat_o <= '0;
    end else begin
      done_o      <= 1'b0;
      wb.wb_ack_o <= acc;
      wb.wb_dat_o <= (acc && !wb.wb_we_i) ? rdata : '0;

      unique case (state)
        ST_HOME: begin
          pos      <= '0;
          steps    <= NST;
          dir      <= 1'b0;
          mv_store <= 1'b0;
          homing   <= 1'b1;
          homed    <= 1'b0;
          UDn_o    <= 1'b0;
          CSn_o    <= 1'b0;
          state    <= ST_SETUP;
        end
        ST_IDLE: begin
          if (home_req) begin
            state <= ST_HOME;
          end else if (pend_v) begin
            pend_v <= 1'b0;
            if (go) begin
              steps    <= (tgt_q > pos) ? {1'b0, tgt_q - pos}
                                        : {1'b0, pos - tgt_q};
              dir      <= (tgt_q > pos);
              UDn_o    <= (tgt_q > pos);
              mv_store <= st_q;
              CSn_o    <= 1'b0;
              state    <= ST_SETUP;
            end
          end
        end
        ST_SETUP: if (tm_exp) begin
          if (steps != '0) begin
            INC_o <= 1'b0;
            pos   <= step_pos(pos, dir);
            state <= ST_INC_LO;
          end else begin
            INC_o   <= mv_store;
            tail_ph <= 1'b0;
            state   <= ST_TAIL;
          end
        end
        ST_INC_LO: if (tm_exp) begin
          INC_o <= 1'b1;
          steps <= steps - 1'b1;
          state <= ST_INC_HI;
        end
        ST_INC_HI: if (tm_exp) begin
          if (steps != '0) begin
            INC_o <= 1'b0;
            pos   <= step_pos(pos, dir);
            state <= ST_INC_LO;
          end else begin
            // INC left low here makes the CSn rise a deselect, not a store
            INC_o   <= mv_store;
            tail_ph <= 1'b0;
            state   <= ST_TAIL;
          end
        end
        ST_TAIL: begin
          if (tail_ph) begin
            INC_o  <= 1'b1;
            done_o <= 1'b1;
            homed  <= homed | homing;
            homing <= 1'b0;
            state  <= ST_IDLE;
          end else if (tm_exp) begin
            CSn_o <= 1'b1;
            if (mv_store) state <= ST_STORE;
            else          tail_ph <= 1'b1;
          end
        end
        ST_STORE: if (tm_exp) begin
          done_o <= 1'b1;
          homed  <= homed | homing;
          homing <= 1'b0;
          state  <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase

      if (wr_any && (ra == REG_TARGET)) begin
        tgt_q  <= wtgt;
        st_q   <= wb.wb_dat_i[TGT_STORE];
        pend_v <= 1'b1;
        if (wclamp) err <= 1'b1;
      end
      if (wr_any && (ra == REG_CTRL) && wb.wb_dat_i[CTRL_CLR])
        err <= 1'b0;
    end
  end
endmodule

// File: tb/tb_digpot_seq.sv
// Directed bench for digpot_seq.
// Pin activity is tallied by a monitor; the main sequence checks the tallies.
module tb_digpot_seq;
  localparam int HALF = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic inc, udn, csn, busy, done;
  int tests = 0;
  int fails = 0;

  digpot_wb_if w ();

  digpot_seq #(
    .NSTEPS(100), .POS_W(7), .HALF_CYC(HALF),
    .SETUP_CYC(2), .STORE_CYC(10)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .wb     (w),
    .INC_o  (inc),
    .UDn_o  (udn),
    .CSn_o  (csn),
    .busy_o (busy),
    .done_o (done)
  );

  always #5 clk = ~clk;

  int pulses = 0, ups = 0, dns = 0;
  int bad_len = 0, bad_gap = 0, ud_bad = 0;
  int done_cnt = 0, busy_cnt = 0, csb_cnt = 0;
  int cyc_n = 0, lo_len = 0, last_fall = -1;
  logic inc_p = 1'b1, cs_p = 1'b1, ud_p = 1'b0;
  logic cs_rise_inc = 1'bx;

  always @(negedge clk) begin
    cyc_n++;
    if (udn !== ud_p && inc !== 1'b1) ud_bad++;
    if (inc_p && !inc && !csn) begin
      if (last_fall >= 0 && cyc_n - last_fall != 2*HALF) bad_gap++;
      last_fall = cyc_n;
    end
    if (csn) last_fall = -1;
    if (!inc) lo_len++;
    else begin
      if (!inc_p && !csn) begin
        pulses++;
        if (udn) ups++; else dns++;
        if (lo_len != HALF) bad_len++;
      end
      lo_len = 0;
    end
    if (!cs_p && csn) cs_rise_inc = inc;
    if (done) done_cnt++;
    if (busy) busy_cnt++;
    if (busy && csn) csb_cnt++;
    inc_p = inc;
    cs_p  = csn;
    ud_p  = udn;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wb_xfer(input logic we, input logic [3:0] a,
                         input logic [31:0] d, output logic [31:0] q);
    int n = 0;
    @(posedge clk); #1;
    w.wb_cyc_i = 1'b1;
    w.wb_stb_i = 1'b1;
    w.wb_we_i  = we;
    w.wb_adr_i = {28'd0, a};
    w.wb_dat_i = d;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!w.wb_ack_o && n < 8);
    chk("wb_ack", {31'd0, w.wb_ack_o}, 32'd1);
    q = w.wb_dat_o;
    w.wb_cyc_i = 1'b0;
    w.wb_stb_i = 1'b0;
    w.wb_we_i  = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int d0);
    int n = 0;
    while (done_cnt <= d0 && n < 3000) begin
      @(posedge clk);
      n++;
    end
    chk(tag, {31'd0, done_cnt > d0}, 32'd1);
  endtask

  initial begin
    logic [31:0] q;
    int p0, u0, d0, c0, b0, k0;
    w.wb_cyc_i = 1'b0;
    w.wb_stb_i = 1'b0;
    w.wb_we_i  = 1'b0;
    w.wb_adr_i = '0;
    w.wb_sel_i = 4'hF;
    w.wb_dat_i = '0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_inc", {31'd0, inc}, 32'd1);
    chk("rst_csn", {31'd0, csn}, 32'd1);
    chk("rst_udn", {31'd0, udn}, 32'd0);
    chk("rst_ack", {31'd0, w.wb_ack_o}, 32'd0);
    chk("rst_dat", w.wb_dat_o, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);

    p0 = pulses; d0 = dns; c0 = done_cnt;
    reset = 1'b0;
    wait_done("home_done", c0);
    chk("home_pulses", pulses - p0, 100);
    chk("home_down", dns - d0, 100);
    chk("home_cs_inc", {31'd0, cs_rise_inc}, 32'd0);
    wb_xfer(1'b0, 4'h4, 0, q);
    chk("home_status", q, 32'h200);

    p0 = pulses; u0 = ups; c0 = done_cnt;
    wb_xfer(1'b1, 4'h0, 37, q);
    wait_done("mv37_done", c0);
    chk("mv37_pulses", pulses - p0, 37);
    chk("mv37_up", ups - u0, 37);
    chk("mv37_cs_inc", {31'd0, cs_rise_inc}, 32'd0);
    wb_xfer(1'b0, 4'h4, 0, q);
    chk("mv37_status", q, 32'h200 | 37);

    d0 = dns; c0 = done_cnt;
    wb_xfer(1'b1, 4'h0, 30, q);
    wait_done("mv30_done", c0);
    chk("mv30_down", dns - d0, 7);
    wb_xfer(1'b0, 4'h4, 0, q);
    chk("mv30_status", q, 32'h200 | 30);

    u0 = ups; c0 = done_cnt;
    wb_xfer(1'b1, 4'h0, 120, q);
    wb_xfer(1'b0, 4'h4, 0, q);
    chk("clamp_err_busy", q & 32'h500, 32'h500);
    wb_xfer(1'b0, 4'h0, 0, q);
    chk("clamp_target", q, 99);
    wait_done("clamp_done", c0);
    chk("clamp_up", ups - u0, 69);
    wb_xfer(1'b0, 4'h4, 0, q);
    chk("clamp_status", q, 32'h600 | 99);
    wb_xfer(1'b1, 4'h8, 32'h4, q);
    wb_xfer(1'b0, 4'h4, 0, q);
    chk("err_clear", q, 32'h200 | 99);

    d0 = dns; u0 = ups; c0 = done_cnt;
    wb_xfer(1'b1, 4'h0, 50, q);
    wb_xfer(1'b1, 4'h0, 70, q);
    wb_xfer(1'b1, 4'h0, 10, q);
    wait_done("chain_done1", c0);
    chk("chain_down1", dns - d0, 49);
    wait_done("chain_done2", c0 + 1);
    chk("chain_down2", dns - d0, 89);
    chk("chain_up", ups - u0, 0);
    wb_xfer(1'b0, 4'h4, 0, q);
    chk("chain_status", q, 32'h200 | 10);

    p0 = pulses; c0 = done_cnt; k0 = csb_cnt; b0 = busy_cnt;
    wb_xfer(1'b1, 4'h0, 32'h100 | 10, q);
    wait_done("store_done", c0);
    chk("store_pulses", pulses - p0, 0);
    chk("store_cs_inc", {31'd0, cs_rise_inc}, 32'd1);
    chk("store_hold", csb_cnt - k0, 10);
    chk("store_busy", busy_cnt - b0, 14);

    c0 = done_cnt; b0 = busy_cnt;
    wb_xfer(1'b1, 4'h0, 10, q);
    repeat (20) @(posedge clk);
    chk("noop_done", done_cnt - c0, 0);
    chk("noop_busy", busy_cnt - b0, 0);
    wb_xfer(1'b0, 4'h0, 0, q);
    chk("noop_target", q, 10);
    wb_xfer(1'b0, 4'hC, 0, q);
    chk("reg_c_zero", q, 0);

    u0 = ups;
    wb_xfer(1'b1, 4'h0, 40, q);
    k0 = 0;
    while (ups - u0 < 10 && k0 < 1000) begin
      @(posedge clk);
      k0++;
    end
    chk("mid_reach20", ups - u0, 10);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_inc", {31'd0, inc}, 32'd1);
    chk("mid_rst_csn", {31'd0, csn}, 32'd1);
    p0 = pulses; d0 = dns; c0 = done_cnt;
    reset = 1'b0;
    wb_xfer(1'b0, 4'h4, 0, q);
    chk("rehome_status", q, 32'h100);
    wait_done("rehome_done", c0);
    chk("rehome_pulses", pulses - p0, 100);
    chk("rehome_down", dns - d0, 100);
    wb_xfer(1'b0, 4'h4, 0, q);
    chk("rehome_final", q, 32'h200);

    chk("inc_low_len", bad_len, 0);
    chk("inc_spacing", bad_gap, 0);
    chk("udn_stable", ud_bad, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
